// File: rtl/nf_i_fetch_unit_pkg.sv
// Shared fetch-stage types and constants: FSM encoding, NOP encoding, reset PC.
package nf_i_fetch_unit_pkg;

  typedef enum logic [1:0] {
    F_START = 2'd0,
    F_REQ   = 2'd1,
    F_HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] INSTR_NOP_DEF = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/nf_i_fetch_hold_buf.sv
// One-entry skid buffer catching a fetched instruction while decode is stalled.
module nf_i_fetch_hold_buf
  import nf_i_fetch_unit_pkg::*;
#(
  parameter logic [31:0] INSTR_NOP = INSTR_NOP_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load_i,
  input  logic        unload_i,
  input  logic        clear_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        vld_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  logic        vld_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;

  // clear beats load so a same-cycle flush never leaves a stale entry
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_q   <= 1'b0;
      instr_q <= INSTR_NOP;
      pc_q    <= '0;
    end else if (clear_i) begin
      vld_q   <= 1'b0;
    end else if (load_i) begin
      vld_q   <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end else if (unload_i) begin
      vld_q   <= 1'b0;
    end
  end

  assign vld_o   = vld_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/nf_i_fetch_unit.sv
// Instruction fetch: owns the PC, drives the req/ack memory port, feeds decode,
// and handles branch redirect, decode stall and decode flush.
module nf_i_fetch_unit
  import nf_i_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] INSTR_NOP = INSTR_NOP_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [31:0] addr_i,
  output logic        req_i,
  input  logic [31:0] rd_i,
  input  logic        req_ack_i,
  input  logic [31:0] pc_branch,
  input  logic        we_branch,
  input  logic        stall_if,
  input  logic        flush_id,
  output logic [31:0] instr_id,
  output logic [31:0] pc_id,
  output logic        instr_vld_id
);

  fetch_state_e state_q;
  logic [31:0]  pc_q, instr_q, pcid_q, tgt_q;
  logic         vld_q, pend_q;

  logic         req_out, ack, br_now;
  logic         hb_load, hb_unload, hb_clr, hb_vld;
  logic [31:0]  hb_instr, hb_pc;

  assign req_out = (state_q == F_REQ);
  assign ack     = req_out & req_ack_i;
  // redirect applies at once unless it would change addr_i under an unacked request
  assign br_now  = we_branch & (~req_out | req_ack_i);

  always_comb begin
    hb_clr    = we_branch | flush_id;
    hb_load   = ~we_branch & ~flush_id & stall_if & ack & ~pend_q;
    hb_unload = ~we_branch & ~flush_id & ~stall_if & (state_q == F_HOLD);
  end

  nf_i_fetch_hold_buf #(.INSTR_NOP(INSTR_NOP)) u_hold_buf (
    .clk      (clk),
    .resetn   (resetn),
    .load_i   (hb_load),
    .unload_i (hb_unload),
    .clear_i  (hb_clr),
    .instr_i  (rd_i),
    .pc_i     (pc_q),
    .vld_o    (hb_vld),
    .instr_o  (hb_instr),
    .pc_o     (hb_pc)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= F_START;
      pc_q    <= RESET_PC;
      instr_q <= INSTR_NOP;
      pcid_q  <= '0;
      vld_q   <= 1'b0;
      pend_q  <= 1'b0;
      tgt_q   <= '0;
    end else if (we_branch) begin
      instr_q <= INSTR_NOP;
      vld_q   <= 1'b0;
      if (br_now) begin
        pc_q    <= word_align(pc_branch);
        pend_q  <= 1'b0;
        state_q <= F_REQ;
      end else begin
        tgt_q  <= word_align(pc_branch);
        pend_q <= 1'b1;
      end
    end else begin
      // an ack is always consumed; wrong-path data after a redirect is dropped
      if (ack) begin
        pc_q   <= pend_q ? tgt_q : pc_q + 32'd4;
        pend_q <= 1'b0;
      end
      if (flush_id) begin
        instr_q <= INSTR_NOP;
        vld_q   <= 1'b0;
        if (state_q != F_REQ) state_q <= F_REQ;
      end else if (stall_if) begin
        if (state_q == F_START)    state_q <= F_REQ;
        else if (ack && !pend_q)   state_q <= F_HOLD;
      end else begin
        unique case (state_q)
          F_HOLD: begin
            instr_q <= hb_instr;
            pcid_q  <= hb_pc;
            vld_q   <= hb_vld;
            state_q <= F_REQ;
          end
          F_REQ: begin
            if (ack && !pend_q) begin
              instr_q <= rd_i;
              pcid_q  <= pc_q;
              vld_q   <= 1'b1;
            end else begin
              instr_q <= INSTR_NOP;
              vld_q   <= 1'b0;
            end
          end
          default: begin
            instr_q <= INSTR_NOP;
            vld_q   <= 1'b0;
            state_q <= F_REQ;
          end
        endcase
      end
    end
  end

  assign addr_i       = pc_q;
  assign req_i        = req_out;
  assign instr_id     = instr_q;
  assign pc_id        = pcid_q;
  assign instr_vld_id = vld_q;

endmodule

// File: tb/tb_nf_i_fetch_unit.sv
// Directed, table-driven bench for nf_i_fetch_unit plus a mid-request reset sequence.
module tb_nf_i_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] addr_i, rd_i, pc_branch, instr_id, pc_id;
  logic        req_i, req_ack_i, we_branch, stall_if, flush_id, instr_vld_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nf_i_fetch_unit dut (
    .clk          (clk),
    .resetn       (resetn),
    .addr_i       (addr_i),
    .req_i        (req_i),
    .rd_i         (rd_i),
    .req_ack_i    (req_ack_i),
    .pc_branch    (pc_branch),
    .we_branch    (we_branch),
    .stall_if     (stall_if),
    .flush_id     (flush_id),
    .instr_id     (instr_id),
    .pc_id        (pc_id),
    .instr_vld_id (instr_vld_id)
  );

  typedef struct {
    logic [31:0] rd;
    logic        ack;
    logic        br;
    logic [31:0] pcb;
    logic        stall;
    logic        flush;
    logic [31:0] e_addr;
    logic        e_req;
    logic [31:0] e_instr;
    logic [31:0] e_pcid;
    logic        e_vld;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic [31:0] rd, input logic ack, input logic br,
                     input logic [31:0] pcb, input logic stall, input logic flush,
                     input logic [31:0] e_addr, input logic e_req,
                     input logic [31:0] e_instr, input logic [31:0] e_pcid,
                     input logic e_vld);
    vec_t v;
    v.rd = rd; v.ack = ack; v.br = br; v.pcb = pcb; v.stall = stall; v.flush = flush;
    v.e_addr = e_addr; v.e_req = e_req; v.e_instr = e_instr; v.e_pcid = e_pcid;
    v.e_vld = e_vld;
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [95:0] act,
                     input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] rd, input logic ack, input logic br,
                       input logic [31:0] pcb, input logic stall, input logic flush);
    rd_i = rd; req_ack_i = ack; we_branch = br; pc_branch = pcb;
    stall_if = stall; flush_id = flush;
  endtask

  initial begin
    //    rd            ack br pcb           st fl  addr          req instr         pcid          vld
    add(32'h0,         0, 0, 32'h0,         0, 0, 32'h0,        0, NOP,          32'h0,        0); // F_START
    add(32'h000000A0,  1, 0, 32'h0,         0, 0, 32'h0,        1, 32'h000000A0, 32'h0,        1);
    add(32'h000000A4,  1, 0, 32'h0,         0, 0, 32'h4,        1, 32'h000000A4, 32'h4,        1);
    add(32'h00500093,  1, 0, 32'h0,         1, 0, 32'h8,        1, 32'h000000A4, 32'h4,        1); // stall on ack
    add(32'h0,         0, 0, 32'h0,         1, 0, 32'hC,        0, 32'h000000A4, 32'h4,        1);
    add(32'h0,         0, 0, 32'h0,         1, 0, 32'hC,        0, 32'h000000A4, 32'h4,        1);
    add(32'h0,         0, 0, 32'h0,         0, 0, 32'hC,        0, 32'h00500093, 32'h8,        1); // unload
    add(32'h0,         0, 0, 32'h0,         0, 0, 32'hC,        1, NOP,          32'h8,        0); // bubble
    add(32'h00000B0C,  1, 0, 32'h0,         0, 0, 32'hC,        1, 32'h00000B0C, 32'hC,        1);
    add(32'h0,         0, 1, 32'h100,       0, 0, 32'h10,       1, NOP,          32'hC,        0); // redirect pending
    add(32'h0,         0, 0, 32'h0,         0, 0, 32'h10,       1, NOP,          32'hC,        0);
    add(32'h0000DEAD,  1, 0, 32'h0,         0, 0, 32'h10,       1, NOP,          32'hC,        0); // dropped
    add(32'h0000C100,  1, 0, 32'h0,         0, 0, 32'h100,      1, 32'h0000C100, 32'h100,      1);
    add(32'h0,         0, 1, 32'h200,       0, 0, 32'h104,      1, NOP,          32'h100,      0);
    add(32'h0,         0, 1, 32'h300,       0, 0, 32'h104,      1, NOP,          32'h100,      0); // overwrite
    add(32'h0000BEEF,  1, 0, 32'h0,         0, 0, 32'h104,      1, NOP,          32'h100,      0);
    add(32'h0000C300,  1, 0, 32'h0,         0, 0, 32'h300,      1, 32'h0000C300, 32'h300,      1);
    add(32'h0000C304,  1, 0, 32'h0,         1, 0, 32'h304,      1, 32'h0000C300, 32'h300,      1); // into hold
    add(32'h0,         0, 1, 32'h40,        1, 1, 32'h308,      0, NOP,          32'h300,      0); // br+flush
    add(32'h0,         0, 0, 32'h0,         0, 0, 32'h40,       1, NOP,          32'h300,      0);
    add(32'h0000C040,  1, 0, 32'h0,         0, 0, 32'h40,       1, 32'h0000C040, 32'h40,       1);
    add(32'h0,         0, 0, 32'h0,         0, 1, 32'h44,       1, NOP,          32'h40,       0); // flush only
    add(32'h0000C044,  1, 0, 32'h0,         0, 0, 32'h44,       1, 32'h0000C044, 32'h44,       1);
    add(32'h0,         0, 0, 32'h0,         1, 0, 32'h48,       1, 32'h0000C044, 32'h44,       1); // stall, no ack
    add(32'h0000C048,  1, 1, 32'hFFFFFFFF,  0, 0, 32'h48,       1, NOP,          32'h44,       0); // br with ack
    add(32'h0000CFFC,  1, 0, 32'h0,         0, 0, 32'hFFFFFFFC, 1, 32'h0000CFFC, 32'hFFFFFFFC, 1);
    add(32'h0000C000,  1, 0, 32'h0,         0, 0, 32'h0,        1, 32'h0000C000, 32'h0,        1); // wrapped

    resetn = 1'b0;
    drive(32'h0, 0, 0, 32'h0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 0, {addr_i, req_i, instr_id, pc_id, instr_vld_id},
        {32'h0, 1'b0, NOP, 32'h0, 1'b0});

    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].rd, tv[i].ack, tv[i].br, tv[i].pcb, tv[i].stall, tv[i].flush);
      #1;
      chk("mem_port", i, {addr_i, req_i}, {tv[i].e_addr, tv[i].e_req});
      @(posedge clk);
      #1;
      chk("decode", i, {instr_id, pc_id, instr_vld_id},
          {tv[i].e_instr, tv[i].e_pcid, tv[i].e_vld});
      @(negedge clk);
    end

    // reset asserted while a request is outstanding with no ack yet
    drive(32'h0, 0, 0, 32'h0, 0, 0);
    #1;
    chk("pre_rst_req", 0, {addr_i, req_i}, {32'h4, 1'b1});
    resetn = 1'b0;
    #1;
    chk("async_rst", 0, {addr_i, req_i, instr_id, pc_id, instr_vld_id},
        {32'h0, 1'b0, NOP, 32'h0, 1'b0});
    @(negedge clk);
    resetn = 1'b1;
    drive(32'h00000BAD, 1, 0, 32'h0, 0, 0); // late ack during F_START
    #1;
    chk("start_port", 0, {addr_i, req_i}, {32'h0, 1'b0});
    @(posedge clk);
    #1;
    chk("start_ack_ignored", 0, {addr_i, req_i, instr_id, pc_id, instr_vld_id},
        {32'h0, 1'b1, NOP, 32'h0, 1'b0});
    @(negedge clk);
    drive(32'h00000600, 1, 0, 32'h0, 0, 0);
    @(posedge clk);
    #1;
    chk("first_after_rst", 0, {addr_i, req_i, instr_id, pc_id, instr_vld_id},
        {32'h4, 1'b1, 32'h00000600, 32'h0, 1'b1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
